object_reader: RTL and testbench

Post-frame reader for the connected-components object tables. When a frame finishes, it walks labels `1 .. num_labels-1`. For each label it reads the merge table and the data table, and keeps only root labels whose area meets a minimum. It computes each kept object's centroid with a sequential divider and emits one record per object on a valid/ready stream. It sits after the labeling block and reads the same merge-table and data-table read ports that the labeler writes.

---
 rtl/object_reader.sv | 176 +++++++++++++++++
 tb/tb_object_reader.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/object_reader.sv
// object_reader: post-frame walk over the connected-components tables.
// Visits labels 1 .. num_labels-1 and keeps each root label whose area is at
// least MIN_AREA. For every kept label it divides both coordinate sums by the
// area with a restoring divider and emits one record on a valid/ready stream.
module object_reader #(
  parameter int WORD_SIZE   = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int COORD_WIDTH = 16,
  parameter int MIN_AREA    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_SIZE-1:0]   num_labels,
  output logic [WORD_SIZE-1:0]   mt_addr,
  input  logic [WORD_SIZE-1:0]   mt_data,
  output logic [WORD_SIZE-1:0]   dt_addr,
  input  logic [ACC_WIDTH-1:0]   dt_area,
  input  logic [ACC_WIDTH-1:0]   dt_x_acc,
  input  logic [ACC_WIDTH-1:0]   dt_y_acc,
  output logic                   obj_valid,
  input  logic                   obj_ready,
  output logic [WORD_SIZE-1:0]   obj_id,
  output logic [COORD_WIDTH-1:0] obj_x,
  output logic [COORD_WIDTH-1:0] obj_y,
  output logic [ACC_WIDTH-1:0]   obj_area,
  output logic                   busy,
  output logic                   done
);

  localparam int CNT_W = $clog2(ACC_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_DIV,
    S_OUT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WORD_SIZE-1:0] cur;
  logic [WORD_SIZE-1:0] last;
  logic [WORD_SIZE-1:0] last_m1;
  logic [ACC_WIDTH-1:0] area_r;
  logic [ACC_WIDTH-1:0] x_dvd, y_dvd;  // dividends, consumed MSB first
  logic [ACC_WIDTH-1:0] x_q, y_q;      // quotients, built LSB first
  logic [ACC_WIDTH-1:0] x_r, y_r;      // partial remainders, always < area_r
  logic [CNT_W-1:0]     cnt;
  logic                 keep;
  logic                 at_end;
  logic [ACC_WIDTH:0]   x_step, y_step;  // {quotient bit, next remainder}

  // One restoring step: bring in the next dividend bit and subtract the
  // divisor when it fits. The remainder is below the divisor, so the shifted
  // value stays below 2*divisor and the borrow bit is a reliable sign.
  function automatic logic [ACC_WIDTH:0] div_step(
    input logic [ACC_WIDTH-1:0] rem,
    input logic                 msb,
    input logic [ACC_WIDTH-1:0] divisor
  );
    logic [ACC_WIDTH:0] shifted;
    logic [ACC_WIDTH:0] diff;
    shifted = {rem, msb};
    diff    = shifted - {1'b0, divisor};
    if (diff[ACC_WIDTH]) div_step = {1'b0, shifted[ACC_WIDTH-1:0]};
    else                 div_step = {1'b1, diff[ACC_WIDTH-1:0]};
  endfunction

  // Quotients wider than the coordinate field clamp to all-ones.
  function automatic logic [COORD_WIDTH-1:0] saturate(input logic [ACC_WIDTH-1:0] q);
    if ((q >> COORD_WIDTH) != '0) saturate = '1;
    else                          saturate = q[COORD_WIDTH-1:0];
  endfunction

  assign last_m1 = last - WORD_SIZE'(1);
  assign at_end  = (cur == last_m1);
  assign keep    = (mt_data == cur) && (dt_area >= ACC_WIDTH'(MIN_AREA));
  assign x_step  = div_step(x_r, x_dvd[ACC_WIDTH-1], area_r);
  assign y_step  = div_step(y_r, y_dvd[ACC_WIDTH-1], area_r);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every register in an always_ff uses <= so all flops update from
    // pre-edge values regardless of statement order.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode for the label walk.
  always_comb begin
    // NOTE: the default assignment first means every path assigns state_nxt,
    // so no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (num_labels <= WORD_SIZE'(1)) ? S_DONE : S_FETCH;
      S_FETCH: state_nxt = S_CHECK;
      S_CHECK: begin
        if (keep)        state_nxt = S_DIV;
        else if (at_end) state_nxt = S_DONE;
        else             state_nxt = S_FETCH;
      end
      S_DIV:   if (cnt == CNT_W'(1)) state_nxt = S_OUT;
      S_OUT:   if (obj_ready) state_nxt = at_end ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Label index, latched table entry and the two parallel dividers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur    <= '0;
      last   <= '0;
      area_r <= '0;
      x_dvd  <= '0;
      y_dvd  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      x_r    <= '0;
      y_r    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            last <= num_labels;
            if (num_labels > WORD_SIZE'(1)) cur <= WORD_SIZE'(1);
          end
        end
        S_CHECK: begin
          if (keep) begin
            area_r <= dt_area;
            x_dvd  <= dt_x_acc;
            y_dvd  <= dt_y_acc;
            x_q    <= '0;
            y_q    <= '0;
            x_r    <= '0;
            y_r    <= '0;
            cnt    <= CNT_W'(ACC_WIDTH);
          end else if (!at_end) begin
            cur <= cur + WORD_SIZE'(1);
          end
        end
        S_DIV: begin
          x_dvd <= x_dvd << 1;
          y_dvd <= y_dvd << 1;
          x_q   <= {x_q[ACC_WIDTH-2:0], x_step[ACC_WIDTH]};
          y_q   <= {y_q[ACC_WIDTH-2:0], y_step[ACC_WIDTH]};
          x_r   <= x_step[ACC_WIDTH-1:0];
          y_r   <= y_step[ACC_WIDTH-1:0];
          cnt   <= cnt - CNT_W'(1);
        end
        S_OUT: begin
          if (obj_ready && !at_end) cur <= cur + WORD_SIZE'(1);
        end
        default: ;
      endcase
    end
  end

  // Both tables are addressed straight from the label register; the record
  // comes from registers only, so obj_valid never sees obj_ready.
  assign mt_addr   = cur;
  assign dt_addr   = cur;
  assign obj_valid = (state == S_OUT);
  assign obj_id    = cur;
  assign obj_area  = area_r;
  assign obj_x     = saturate(x_q);
  assign obj_y     = saturate(y_q);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_object_reader.sv
// Bench for object_reader: table model, reference record scoreboard, timing
// and handshake checks. Two instances: MIN_AREA=1 and MIN_AREA=3.
module tb_object_reader;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] area;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start3 = 1'b0;
  logic        obj_ready = 1'b1;
  logic [7:0]  num_labels = '0;

  logic [7:0]  mt_tab [256];
  logic [31:0] ar_tab [256];
  logic [31:0] xa_tab [256];
  logic [31:0] ya_tab [256];

  logic [7:0]  mt_addr, mt_data, dt_addr, obj_id;
  logic [31:0] dt_area, dt_x_acc, dt_y_acc, obj_area;
  logic [15:0] obj_x, obj_y;
  logic        obj_valid, busy, done;

  logic [7:0]  mt_addr3, mt_data3, dt_addr3, obj_id3;
  logic [31:0] dt_area3, dt_x_acc3, dt_y_acc3, obj_area3;
  logic [15:0] obj_x3, obj_y3;
  logic        obj_valid3, busy3, done3;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  rec_t exp_q[$];
  rec_t exp_q3[$];
  int rise_cyc = 0, done_cyc = 0, done_cnt = 0, acc_cnt = 0, acc_cnt3 = 0;
  int valid_cnt = 0, busy_cnt = 0;
  logic prev_stall = 1'b0, prev_valid = 1'b0;
  rec_t held;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  object_reader #(.WORD_SIZE(8), .ACC_WIDTH(32), .COORD_WIDTH(16), .MIN_AREA(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .num_labels(num_labels),
    .mt_addr(mt_addr), .mt_data(mt_data), .dt_addr(dt_addr),
    .dt_area(dt_area), .dt_x_acc(dt_x_acc), .dt_y_acc(dt_y_acc),
    .obj_valid(obj_valid), .obj_ready(obj_ready), .obj_id(obj_id),
    .obj_x(obj_x), .obj_y(obj_y), .obj_area(obj_area), .busy(busy), .done(done)
  );

  object_reader #(.WORD_SIZE(8), .ACC_WIDTH(32), .COORD_WIDTH(16), .MIN_AREA(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .num_labels(num_labels),
    .mt_addr(mt_addr3), .mt_data(mt_data3), .dt_addr(dt_addr3),
    .dt_area(dt_area3), .dt_x_acc(dt_x_acc3), .dt_y_acc(dt_y_acc3),
    .obj_valid(obj_valid3), .obj_ready(obj_ready), .obj_id(obj_id3),
    .obj_x(obj_x3), .obj_y(obj_y3), .obj_area(obj_area3), .busy(busy3), .done(done3)
  );

  // Synchronous-read table model: data valid one cycle after the address.
  always @(posedge clk) begin
    mt_data   <= mt_tab[mt_addr];
    dt_area   <= ar_tab[dt_addr];
    dt_x_acc  <= xa_tab[dt_addr];
    dt_y_acc  <= ya_tab[dt_addr];
    mt_data3  <= mt_tab[mt_addr3];
    dt_area3  <= ar_tab[dt_addr3];
    dt_x_acc3 <= xa_tab[dt_addr3];
    dt_y_acc3 <= ya_tab[dt_addr3];
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor for the MIN_AREA=1 instance: scoreboard, hold checks, event log.
  always @(negedge clk) begin
    rec_t cur_rec;
    rec_t e;
    cur_rec = {obj_id, obj_x, obj_y, obj_area};
    if (prev_stall && !reset) begin
      check("hold_valid", obj_valid, 1'b1);
      check("hold_record", cur_rec, held);
    end
    if (obj_valid && !prev_valid) rise_cyc = cyc;
    if (obj_valid) valid_cnt++;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (obj_valid && obj_ready) begin
      acc_cnt++;
      if (exp_q.size() == 0) check("unexpected_record", 1'b1, 1'b0);
      else begin
        e = exp_q.pop_front();
        check("rec_id", obj_id, e.id);
        check("rec_x", obj_x, e.x);
        check("rec_y", obj_y, e.y);
        check("rec_area", obj_area, e.area);
      end
    end
    prev_stall = obj_valid && !obj_ready;
    prev_valid = obj_valid;
    held       = cur_rec;
  end

  // Monitor for the MIN_AREA=3 instance: scoreboard only.
  always @(negedge clk) begin
    rec_t e;
    if (obj_valid3 && obj_ready) begin
      acc_cnt3++;
      if (exp_q3.size() == 0) check("unexpected_record3", 1'b1, 1'b0);
      else begin
        e = exp_q3.pop_front();
        check("rec3_id", obj_id3, e.id);
        check("rec3_x", obj_x3, e.x);
        check("rec3_y", obj_y3, e.y);
        check("rec3_area", obj_area3, e.area);
      end
    end
  end

  task automatic clear_tables();
    for (int i = 0; i < 256; i++) begin
      mt_tab[i] = '0;
      ar_tab[i] = '0;
      xa_tab[i] = '0;
      ya_tab[i] = '0;
    end
  endtask

  task automatic set_label(input int l, input logic [7:0] mt, input logic [31:0] a,
                           input logic [31:0] xa, input logic [31:0] ya);
    mt_tab[l] = mt;
    ar_tab[l] = a;
    xa_tab[l] = xa;
    ya_tab[l] = ya;
  endtask

  // Reference model: the records the walk must produce, in label order.
  task automatic load_expect(input int n, input int min_area, input bit to3);
    rec_t r;
    logic [31:0] qx, qy;
    for (int l = 1; l < n; l++) begin
      if (mt_tab[l] == l[7:0] && ar_tab[l] >= min_area) begin
        qx     = xa_tab[l] / ar_tab[l];
        qy     = ya_tab[l] / ar_tab[l];
        r.id   = l[7:0];
        r.x    = (qx > 32'hFFFF) ? 16'hFFFF : qx[15:0];
        r.y    = (qy > 32'hFFFF) ? 16'hFFFF : qy[15:0];
        r.area = ar_tab[l];
        if (to3) exp_q3.push_back(r);
        else     exp_q.push_back(r);
      end
    end
  endtask

  // Pulse start for one cycle; s is the cycle number of the first cycle
  // after start is sampled (FETCH, or DONE for an empty frame).
  task automatic pulse_start(input logic [7:0] n, input bit use3, output int s);
    @(posedge clk); #1;
    num_labels = n;
    if (use3) start3 = 1'b1;
    else      start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    start3 = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input bit use3);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (use3 ? done3 : done) begin
        #1;
        return;
      end
    end
    check("done_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    int a0;
    int a30;
    bit seen;
    clear_tables();

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", obj_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_addr", {mt_addr, dt_addr}, 16'h0);
    check("rst_record", {obj_id, obj_x, obj_y, obj_area}, 72'h0);
    @(posedge clk); #1 reset = 1'b0;

    // Empty frame.
    busy_cnt = 0; valid_cnt = 0; done_cnt = 0;
    pulse_start(8'd1, 1'b0, s);
    wait_done(1'b0);
    check("empty_done_lat", done_cyc - s, 0);
    @(negedge clk);
    check("empty_busy_cycles", busy_cnt, 1);
    check("empty_valid_cycles", valid_cnt, 0);
    check("empty_done_count", done_cnt, 1);

    // Single object.
    clear_tables();
    set_label(1, 8'd1, 32'd4, 32'd10, 32'd22);
    load_expect(2, 1, 1'b0);
    a0 = acc_cnt;
    pulse_start(8'd2, 1'b0, s);
    wait_done(1'b0);
    check("single_valid_lat", rise_cyc - s, 34);
    check("single_done_lat", done_cyc - s, 35);
    check("single_transfers", acc_cnt - a0, 1);
    check("single_queue_empty", exp_q.size(), 0);

    // Merged label skipped.
    clear_tables();
    set_label(1, 8'd1, 32'd6, 32'd12, 32'd6);
    set_label(2, 8'd1, 32'd3, 32'd9, 32'd3);
    set_label(3, 8'd3, 32'd2, 32'd4, 32'd8);
    load_expect(4, 1, 1'b0);
    a0 = acc_cnt;
    pulse_start(8'd4, 1'b0, s);
    wait_done(1'b0);
    check("merged_done_lat", done_cyc - s, 72);
    check("merged_transfers", acc_cnt - a0, 2);
    check("merged_queue_empty", exp_q.size(), 0);

    // Area filter on the MIN_AREA=3 instance.
    clear_tables();
    set_label(1, 8'd1, 32'd2, 32'd5, 32'd5);
    set_label(2, 8'd2, 32'd3, 32'd9, 32'd0);
    load_expect(3, 3, 1'b1);
    a30 = acc_cnt3;
    pulse_start(8'd3, 1'b1, s);
    wait_done(1'b1);
    check("filter_transfers", acc_cnt3 - a30, 1);
    check("filter_queue_empty", exp_q3.size(), 0);

    // Backpressure with a start pulse mid-walk.
    clear_tables();
    set_label(1, 8'd1, 32'd4, 32'd10, 32'd22);
    set_label(2, 8'd2, 32'd5, 32'd50, 32'd7);
    load_expect(3, 1, 1'b0);
    obj_ready = 1'b0;
    done_cnt = 0;
    a0 = acc_cnt;
    pulse_start(8'd3, 1'b0, s);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = obj_valid;
    end
    #1;
    check("bp_valid_seen", seen, 1'b1);
    check("bp_valid_lat", rise_cyc - s, 34);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        num_labels = 8'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (k == 4) obj_ready = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    check("bp_next_fetch_addr", mt_addr, 8'd2);
    check("bp_valid_dropped", obj_valid, 1'b0);
    check("bp_still_busy", busy, 1'b1);
    wait_done(1'b0);
    check("bp_done_lat", done_cyc - s, 75);
    check("bp_done_count", done_cnt, 1);
    check("bp_transfers", acc_cnt - a0, 2);
    check("bp_queue_empty", exp_q.size(), 0);

    // Reset mid-DIV, then a clean walk with a saturating centroid.
    clear_tables();
    set_label(1, 8'd1, 32'd1, 32'h0010_0000, 32'd3);
    load_expect(2, 1, 1'b0);
    done_cnt = 0;
    pulse_start(8'd2, 1'b0, s);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_valid", obj_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_addr", mt_addr, 8'd0);
    check("midrst_record", {obj_id, obj_x, obj_y, obj_area}, 72'h0);
    valid_cnt = 0;
    repeat (50) @(negedge clk);
    #1;
    check("midrst_no_done", done_cnt, 0);
    check("midrst_no_valid", valid_cnt, 0);
    exp_q.delete();
    load_expect(2, 1, 1'b0);
    a0 = acc_cnt;
    pulse_start(8'd2, 1'b0, s);
    @(negedge clk);
    check("restart_first_label", mt_addr, 8'd1);
    wait_done(1'b0);
    check("restart_done_lat", done_cyc - s, 35);
    check("restart_transfers", acc_cnt - a0, 1);
    check("restart_queue_empty", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
